// File: rtl/mips_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mips_pkg;
  localparam int MD_WIDTH   = 32;
  localparam int MD_LATENCY = MD_WIDTH + 2;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;
endpackage

// File: rtl/md_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide over the {part_hi, part_lo} pair.
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] part_hi,
  input  logic [WIDTH-1:0] part_lo,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo,
  output logic             q_bit
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum   = {1'b0, part_hi} + (part_lo[0] ? {1'b0, operand} : '0);
    trial = {part_hi, part_lo[WIDTH-1]};
    // remainder stays below the divisor, so the low WIDTH bits of the difference suffice
    diff  = trial[WIDTH-1:0] - operand;
    q_bit  = 1'b0;
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], part_lo[WIDTH-1:1]};
    if (is_div) begin
      q_bit  = (trial >= {1'b0, operand});
      nxt_hi = q_bit ? diff : trial[WIDTH-1:0];
      nxt_lo = {part_lo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; WIDTH+2 edges per op.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  md_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d, div0_q, div0_d;
  logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] a_q, a_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] w_hi_q, w_hi_d, w_lo_q, w_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  md_op_t             op_in;
  logic               signed_op, a_neg, b_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               step_q;

  md_step #(.WIDTH(WIDTH)) u_step (
    .part_hi (w_hi_q),
    .part_lo (w_lo_q),
    .operand (opnd_q),
    .is_div  (is_div_q),
    .nxt_hi  (step_hi),
    .nxt_lo  (step_lo),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start) state_d = MD_RUN;
      MD_RUN:  if (cnt_q == '0) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != MD_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  always_comb begin
    op_in     = md_op_t'(op);
    signed_op = (op_in == MD_MULT) || (op_in == MD_DIV);
    a_neg     = signed_op & src_a[WIDTH-1];
    b_neg     = signed_op & src_b[WIDTH-1];
    prod      = {w_hi_q, w_lo_q};
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    a_d      = a_q;
    opnd_d   = opnd_q;
    w_hi_d   = w_hi_q;
    w_lo_d   = w_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          // multiplier and dividend both start in the low half; operand is the other source
          is_div_d = (op_in == MD_DIV) || (op_in == MD_DIVU);
          div0_d   = (src_b == '0);
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          a_d      = src_a;
          opnd_d   = b_neg ? -src_b : src_b;
          w_lo_d   = a_neg ? -src_a : src_a;
          w_hi_d   = '0;
          cnt_d    = CW'(WIDTH - 1);
        end else begin
          if (wr_hi) hi_d = src_a;
          if (wr_lo) lo_d = src_a;
        end
      end
      MD_RUN: begin
        w_hi_d = step_hi;
        w_lo_d = step_lo | {{(WIDTH-1){1'b0}}, step_q};
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      MD_FIX: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_lo_q ? -prod : prod;
        end else if (div0_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          lo_d = neg_lo_q ? -w_lo_q : w_lo_q;
          hi_d = neg_hi_q ? -w_hi_q : w_hi_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      a_q      <= '0;
      opnd_q   <= '0;
      w_hi_q   <= '0;
      w_lo_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      w_hi_q   <= w_hi_d;
      w_lo_q   <= w_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against a 64-bit arithmetic model.
module tb_mul_div_unit;
  import mips_pkg::*;
  localparam int W = MD_WIDTH;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           n_chk = 0, n_pass = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // {hi,lo} straight from the arithmetic definition of each op
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    case (o)
      2'd0: return x * y;
      2'd1: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd3) return {a % b, a / b};
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // called at a negedge; returns at the negedge where done is seen
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit wrh, input bit inj);
    int n;
    bit seen, hold_ok, done_busy;
    logic [63:0] e;
    e = ref_md(o, a, b);
    start = 1'b1; op = o; src_a = a; src_b = b; wr_hi = wrh;
    n = 0; seen = 0; hold_ok = 1; done_busy = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1;
        done_busy = busy;
      end else if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) hold_ok = 0;
      if (n == 1) begin start = 1'b0; wr_hi = 1'b0; end
      if (inj) begin
        case (n)
          2: begin start = 1'b1; op = 2'd3; src_a = 32'd9; src_b = 32'd3; end
          3: begin start = 1'b0; wr_lo = 1'b1; src_a = 32'hDEAD; end
          4: wr_lo = 1'b0;
          default: ;
        endcase
      end
    end
    start = 1'b0; wr_lo = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(MD_LATENCY));
    chk({tag, "_done_busy"}, 64'(done_busy), 64'd0);
    chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] v);
    wr_hi = h; wr_lo = l; src_a = v;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    chk("mt_hi", 64'(hi), 64'(m_hi));
    chk("mt_lo", 64'(lo), 64'(m_lo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $urandom_range(0, 20);
      2: return 32'h8000_0000;
      default: return 32'hFFFF_FFFF - $urandom_range(0, 8);
    endcase
  endfunction

  initial begin
    int dn;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    mt(1, 0, 32'h1234);
    run_op("interlock", 2'd1, 32'd2, 32'd3, 0, 1);
    @(negedge clk);
    chk("no_relaunch", 64'(busy), 64'd0);
    mt(1, 0, 32'h5555);
    run_op("start_wins", 2'd1, 32'd6, 32'd7, 1, 0);

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("divu", 2'd3, 32'd100, 32'd7, 0, 0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("divu_z", 2'd3, 32'd5, 32'd0, 0, 0);
    run_op("div_z", 2'd2, 32'hFFFF_FFF9, 32'd0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      run_op($sformatf("rnd%0d", i), ro, ra, rb, 0, 0);
    end

    @(negedge clk);
    start = 1'b1; op = 2'd3; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("midrst_no_done", 64'(dn), 64'd0);
    chk("midrst_hold_lo", 64'(lo), 64'd0);
    run_op("after_rst", 2'd1, 32'd4, 32'd5, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Consumes the two register-file read values (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Its hi/lo outputs feed the MFHI/MFLO write-back path into reg_file's write port.
- Fixed multi-cycle latency; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- start  in  1  launch op with src_a/src_b; accepted only when busy=0
- op  in  2  md_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3; sampled with start
- src_a  in  WIDTH  rs value (multiplicand / dividend)
- src_b  in  WIDTH  rt value (multiplier / divisor)
- wr_hi  in  1  MTHI: hi <= src_a
- wr_lo  in  1  MTLO: lo <= src_a
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: hi/lo just updated by an op
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0.
- Reset mid-operation aborts the op: nothing is written to hi/lo, and there is no done pulse.
- FSM (md_state_t), IDLE -> RUN -> FIX -> IDLE:
  - IDLE: on start, latch op and operands, take magnitudes for signed ops, record the result signs, set counter=WIDTH-1, go to RUN.
  - RUN: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide). Count down; when the counter reaches 0, go to FIX.
  - FIX: apply sign correction, then on the exiting edge write hi/lo and go to IDLE.
- Timing, with start sampled at edge E0:
  - busy=1 in the cycles following edges E0..E32.
  - hi/lo are written at E33.
  - done=1 for exactly the cycle following E33, with busy=0 in that cycle.
  - Total latency is WIDTH+2 edges, fixed and independent of operand values.
- hi/lo are architectural registers and stay unchanged while busy; working registers are internal. An MFHI during busy returns the old value; stalling is the pipeline's job.
- Multiply: the {hi,lo} = full 2*WIDTH product.
  - MULT is signed two's complement.
  - MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
- Divide by zero (both signed and unsigned): lo=all-ones, hi=src_a. Still full latency.
- DIV overflow (src_a=0x80000000, src_b=0xFFFFFFFF): lo=0x80000000, hi=0.
- MTHI/MTLO:
  - Applied at the next edge when busy=0; wr_hi and wr_lo together write both.
  - Ignored while busy.
  - When start and wr_hi/wr_lo are asserted in the same IDLE cycle, start wins and the writes are dropped.
- start while busy: ignored, with no effect on the op in flight.
- A back-to-back start in the done cycle is legal and accepted (busy=0).

Decomposition:
- mips_pkg holds md_op_t, md_state_t, and the localparam MD_LATENCY = WIDTH+2.
- One combinational sub-module, md_step, computes one iteration: inputs are the partial remainder/product, operand and mode; outputs are the next partial value and the quotient bit. It is instantiated once in mul_div_unit.
- The sign-fixup logic stays in the parent.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at the done pulse, hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the start cycle.
- MULT -3 (0xFFFFFFFD) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5 after full latency.
- Busy interlock sequence:
  - MTHI 0x1234 while idle -> hi=0x1234 next cycle.
  - Start MULTU 2 x 3; during busy, assert start (DIVU 9/3) and wr_lo (0xDEAD) -> both ignored; hi reads 0x1234 until the done pulse, then hi=0, lo=6.
  - start+wr_hi in the same idle cycle -> the op runs and hi is not written by wr_hi.
- Reset mid-op: start DIVU 100/7, assert reset at cycle 10 -> next cycle busy=0, hi=lo=0; no done pulse over the following 40 cycles. A new MULTU 4x5 afterwards -> lo=20.
